// File: rtl/shift_arbiter.sv
// -----------------------------------------------------------------------------
// shift_arbiter
//
// Two requesters share one barrel shifter. At most one operation is accepted
// per cycle. The shifted result is registered and presented to a single
// consumer with a valid/ready handshake. When both requesters are valid, a
// priority pointer alternates the grant between them so neither starves.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous reset, active low
//   reqN_valid   requester N offers an operation
//   reqN_ready   requester N's operation is accepted this cycle (valid & ready)
//   reqN_bits    operand
//   reqN_shift   shift amount
//   reqN_dir     0 = logical right shift, 1 = logical left shift
//   res_valid    result register holds an undelivered result
//   res_ready    consumer accepts the result
//   res_bits     shifted result
//   res_id       index of the requester that owns res_bits
//
// State table
//   state | meaning
//   EMPTY | no result pending, res_valid = 0
//   FULL  | result register holds an undelivered result, res_valid = 1
// -----------------------------------------------------------------------------
module shift_arbiter #(
  parameter int width = 8,
  localparam int SW = (width > 1) ? $clog2(width) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [width-1:0] req0_bits,
  input  logic [SW-1:0]    req0_shift,
  input  logic             req0_dir,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [width-1:0] req1_bits,
  input  logic [SW-1:0]    req1_shift,
  input  logic             req1_dir,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [width-1:0] res_bits,
  output logic             res_id
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic prio;
  logic prio_nxt;

  logic can_accept;
  logic contend;
  logic grant0;
  logic grant1;
  logic accept;

  logic [width-1:0] sel_bits;
  logic [SW-1:0]    sel_shift;
  logic             sel_dir;
  logic [width-1:0] shifted;

  // ---------------------------------------------------------------------------
  // Arbitration. Readies depend only on valids, state, res_ready and prio.
  // rst gates the grants so both readies read 0 for the whole reset period,
  // not just after the first edge.
  // ---------------------------------------------------------------------------
  always_comb begin
    can_accept = (state == EMPTY) || res_ready;
    contend    = req0_valid && req1_valid;
    grant0     = rst && can_accept && req0_valid && (!req1_valid || !prio);
    grant1     = rst && can_accept && req1_valid && (!req0_valid ||  prio);
    accept     = grant0 || grant1;
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  // ---------------------------------------------------------------------------
  // Shared shifter datapath, operand muxed by the grant.
  // ---------------------------------------------------------------------------
  always_comb begin
    sel_bits  = grant1 ? req1_bits  : req0_bits;
    sel_shift = grant1 ? req1_shift : req0_shift;
    sel_dir   = grant1 ? req1_dir   : req0_dir;
  end

  // Shift amounts at or beyond the width are reachable when width is not a
  // power of two; those produce zero explicitly.
  always_comb begin
    shifted = '0;
    if (32'(sel_shift) < width) begin
      if (sel_dir) begin
        shifted = sel_bits << sel_shift;
      end else begin
        shifted = sel_bits >> sel_shift;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) begin
          state_nxt = FULL;
        end
      end
      FULL: begin
        // A drain and a new accept in the same cycle keeps the register full,
        // sustaining one result per cycle.
        if (res_ready && !accept) begin
          state_nxt = EMPTY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Priority pointer: after a contended grant it points at the loser.
  // Loser is requester 1 exactly when requester 0 won.
  // ---------------------------------------------------------------------------
  always_comb begin
    prio_nxt = prio;
    if (accept && contend) begin
      prio_nxt = grant0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prio <= 1'b0;
    end else begin
      prio <= prio_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Result register. Only written on an accept, so it holds while stalled.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_bits <= '0;
      res_id   <= 1'b0;
    end else if (accept) begin
      res_bits <= shifted;
      res_id   <= grant1;
    end
  end

  assign res_valid = (state == FULL);

endmodule

// File: tb/tb_shift_arbiter.sv
module tb_shift_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // width = 8 instance
  logic       v0, r0, d0, v1, r1, d1;
  logic [7:0] b0, b1;
  logic [2:0] s0, s1;
  logic       rv, rr, rid;
  logic [7:0] rb;

  // width = 6 instance
  logic       p_v0, p_r0, p_d0, p_v1, p_r1, p_d1;
  logic [5:0] p_b0, p_b1;
  logic [2:0] p_s0, p_s1;
  logic       p_rv, p_rr, p_rid;
  logic [5:0] p_rb;

  shift_arbiter #(.width(8)) u_w8 (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_ready(r0), .req0_bits(b0), .req0_shift(s0), .req0_dir(d0),
    .req1_valid(v1), .req1_ready(r1), .req1_bits(b1), .req1_shift(s1), .req1_dir(d1),
    .res_valid(rv), .res_ready(rr), .res_bits(rb), .res_id(rid)
  );

  shift_arbiter #(.width(6)) u_w6 (
    .clk(clk), .rst(rst),
    .req0_valid(p_v0), .req0_ready(p_r0), .req0_bits(p_b0), .req0_shift(p_s0), .req0_dir(p_d0),
    .req1_valid(p_v1), .req1_ready(p_r1), .req1_bits(p_b1), .req1_shift(p_s1), .req1_dir(p_d1),
    .res_valid(p_rv), .res_ready(p_rr), .res_bits(p_rb), .res_id(p_rid)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural reference for the width-8 instance.
  bit       m_full;
  bit [7:0] m_bits;
  bit       m_id;
  bit       m_prio;

  // Bit-by-bit shift: output bit i takes input bit i-sh (left) or i+sh (right).
  function automatic bit [7:0] shift_ref(input bit [7:0] b, input int sh, input bit left, input int w);
    bit [7:0] o;
    int src;
    o = '0;
    for (int i = 0; i < w; i++) begin
      src = left ? i - sh : i + sh;
      if (src >= 0 && src < w) o[i] = b[src];
    end
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_full = 1'b0;
    m_bits = '0;
    m_id   = 1'b0;
    m_prio = 1'b0;
  endtask

  // One clock cycle on the width-8 instance: drive after the falling edge,
  // check against the model, then advance the model across the rising edge.
  task automatic step(input bit iv0, input bit [7:0] ib0, input bit [2:0] is0, input bit id0,
                      input bit iv1, input bit [7:0] ib1, input bit [2:0] is1, input bit id1,
                      input bit irr);
    bit can, e0, e1;
    @(negedge clk);
    rst = 1'b1;
    v0 = iv0; b0 = ib0; s0 = is0; d0 = id0;
    v1 = iv1; b1 = ib1; s1 = is1; d1 = id1;
    rr = irr;
    #1;
    can = !m_full || irr;
    e0  = can && iv0 && (!iv1 || !m_prio);
    e1  = can && iv1 && (!iv0 ||  m_prio);
    check("req0_ready", 32'(r0), 32'(e0));
    check("req1_ready", 32'(r1), 32'(e1));
    check("res_valid",  32'(rv), 32'(m_full));
    if (m_full) begin
      check("res_bits", 32'(rb),  32'(m_bits));
      check("res_id",   32'(rid), 32'(m_id));
    end
    if (e0 || e1) begin
      m_bits = e1 ? shift_ref(ib1, int'(is1), id1, 8) : shift_ref(ib0, int'(is0), id0, 8);
      m_id   = e1;
      m_full = 1'b1;
      if (iv0 && iv1) m_prio = e0 ? 1'b1 : 1'b0;
    end else if (m_full && irr) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input bit irr);
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, irr);
  endtask

  // Holds reset low with valids high and checks everything is quiet.
  // Reset stays low until the next step releases it on a falling edge.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    v0 = 1'b1; v1 = 1'b1; rr = 1'b1;
    p_v0 = 1'b1;
    #1;
    check("rst_req0_ready", 32'(r0),  32'd0);
    check("rst_req1_ready", 32'(r1),  32'd0);
    check("rst_res_valid",  32'(rv),  32'd0);
    check("rst_res_bits",   32'(rb),  32'd0);
    check("rst_res_id",     32'(rid), 32'd0);
    check("rst_w6_ready",   32'(p_r0), 32'd0);
    check("rst_w6_valid",   32'(p_rv), 32'd0);
    p_v0 = 1'b0;
    model_reset();
  endtask

  initial begin
    rst = 1'b0;
    v0 = 0; b0 = 0; s0 = 0; d0 = 0;
    v1 = 0; b1 = 0; s1 = 0; d1 = 0;
    rr = 1'b1;
    p_v0 = 0; p_b0 = 0; p_s0 = 0; p_d0 = 0;
    p_v1 = 0; p_b1 = 0; p_s1 = 0; p_d1 = 0;
    p_rr = 1'b1;
    model_reset();

    do_reset();

    // Single right shift, accepted on the first edge after release.
    step(1'b1, 8'hB4, 3'd2, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    check("single_ready", 32'(r0), 32'd1);
    idle(1'b0);
    check("single_bits", 32'(rb),  32'h2D);
    check("single_id",   32'(rid), 32'd0);

    // Left shift with truncation, accepted while the previous result drains.
    step(1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 8'h81, 3'd1, 1'b1, 1'b1);
    check("left_ready", 32'(r1), 32'd1);
    idle(1'b1);
    check("left_bits", 32'(rb),  32'h02);
    check("left_id",   32'(rid), 32'd1);

    // Contention from a fresh reset: grants alternate 0,1,0,1.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'(8'h10 + k), 3'd1, 1'b0, 1'b1, 8'(8'h20 + k), 3'd1, 1'b1, 1'b1);
      check("contend_r0", 32'(r0), (k % 2 == 0) ? 32'd1 : 32'd0);
      check("contend_r1", 32'(r1), (k % 2 == 1) ? 32'd1 : 32'd0);
      if (k >= 1) check("contend_valid", 32'(rv), 32'd1);
    end
    idle(1'b1);
    check("contend_last_valid", 32'(rv), 32'd1);
    check("contend_last_id",    32'(rid), 32'd1);
    idle(1'b1);

    // Backpressure: stalled for 3 cycles, then accepted in the release cycle.
    step(1'b1, 8'hF0, 3'd4, 1'b0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 8'h55, 3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0);
      check("bp_ready", 32'(r0), 32'd0);
      check("bp_bits",  32'(rb), 32'h0F);
    end
    step(1'b1, 8'h55, 3'd0, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1);
    check("bp_release_ready", 32'(r0), 32'd1);
    idle(1'b0);
    check("bp_new_bits", 32'(rb), 32'h55);

    // Asynchronous reset while FULL: result disappears without a clock edge.
    check("midrst_pre_valid", 32'(rv), 32'd1);
    #1;
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(rv), 32'd0);
    check("midrst_bits",  32'(rb), 32'd0);
    model_reset();
    idle(1'b0);
    check("midrst_after_valid", 32'(rv), 32'd0);
    idle(1'b1);

    // Width-6 instance: out-of-range and in-range shifts.
    @(negedge clk);
    p_v0 = 1'b1; p_b0 = 6'h3F; p_s0 = 3'd7; p_d0 = 1'b0;
    #1;
    check("w6_ready", 32'(p_r0), 32'd1);
    @(negedge clk);
    p_b0 = 6'h3F; p_s0 = 3'd6; p_d0 = 1'b1;
    #1;
    check("w6_oor_right_valid", 32'(p_rv), 32'd1);
    check("w6_oor_right_bits",  32'(p_rb), 32'd0);
    @(negedge clk);
    p_v0 = 1'b0;
    p_v1 = 1'b1; p_b1 = 6'h3F; p_s1 = 3'd2; p_d1 = 1'b0;
    #1;
    check("w6_oor_left_bits", 32'(p_rb), 32'd0);
    @(negedge clk);
    p_v1 = 1'b0;
    #1;
    check("w6_right2_bits", 32'(p_rb),  32'h0F);
    check("w6_right2_id",   32'(p_rid), 32'd1);

    // Randomized traffic against the model, with one reset in the middle.
    for (int n = 0; n < 600; n++) begin
      if (n == 300) do_reset();
      step(($urandom_range(0, 9) < 7), 8'($urandom), 3'($urandom), 1'($urandom),
           ($urandom_range(0, 9) < 7), 8'($urandom), 3'($urandom), 1'($urandom),
           ($urandom_range(0, 3) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
